// File: rtl/result_writeback_ctrl.sv
// result_writeback_ctrl: buffers result vectors in a skid FIFO and writes them to SRAM at incrementing addresses.
// Optional RESULT_RELU_EN clamps negative lanes to zero at the FIFO output.
module result_writeback_ctrl #(
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 32,
    parameter int ADDRESSSIZE    = 10,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [ADDRESSSIZE-1:0]                 base_addr,
    input  logic [ADDRESSSIZE-1:0]                 num_vec,
    input  logic                                   in_valid,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  in_data,
    input  logic                                   sram_stall,
    output logic                                   sram_we,
    output logic [ADDRESSSIZE-1:0]                 sram_addr,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_din,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overflow
);
    localparam int DW = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0] state, state_nx;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0] rd_ptr, wr_ptr;
    logic [ADDRESSSIZE-1:0] job_len, acc_cnt, wr_cnt, wa;
    logic empty, full, pop, push, drop;
    logic [DW-1:0] head, head_w;
    assign empty = rd_ptr == wr_ptr;
    assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign pop   = !empty && !sram_stall;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign push  = state == RUN && in_valid && (!full || pop);
    assign drop  = state == RUN && in_valid && full && !pop;
    assign head  = mem[rd_ptr[AW-1:0]];
    assign busy  = state == RUN || state == DRAIN;
    assign done  = state == DONE;
`ifdef RESULT_RELU_EN
    always_comb begin
        head_w = head;
        for (int i = 0; i < MATRIX_SIZE; i++)
            head_w[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = head[i*PARTIAL_SUM_BW + PARTIAL_SUM_BW - 1] ?
                '0 : head[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end
`else
    assign head_w = head;
`endif
    always_comb begin
        state_nx = state == IDLE  ? (start ? (num_vec == '0 ? DONE : RUN) : IDLE)
                 : state == RUN   ? ((push && acc_cnt + ADDRESSSIZE'(1) == job_len) ? DRAIN : RUN)
                 : state == DRAIN ? ((empty && wr_cnt == job_len) ? DONE : DRAIN)
                 : IDLE;
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            job_len   <= '0;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            wa        <= '0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            overflow  <= 1'b0;
        end else begin
            state   <= state_nx;
            sram_we <= pop;
            if (state == IDLE && start) begin
                wa       <= base_addr;
                job_len  <= num_vec;
                acc_cnt  <= '0;
                wr_cnt   <= '0;
                overflow <= 1'b0;
            end
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (drop) overflow <= 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                sram_addr <= wa;
                sram_din  <= head_w;
                wa        <= wa + 1'b1;
                wr_cnt    <= wr_cnt + 1'b1;
            end
        end
    end
endmodule
